// File: rtl/rr_issue_scheduler.sv
// rr_issue_scheduler
//   Single-grant issue scheduler for one functional-unit lane. Picks one ready
//   issue-queue entry per cycle using a rotating pointer, with a per-entry age
//   counter that lets long-waiting entries jump the rotation. The grant is
//   registered and held while the FU back-pressures.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   req_i          per-entry ready/request bits
//   fu_ready_i     FU accepts the currently held grant this cycle
//   flush_i        drop the held grant and clear all ages (pointer is kept)
//   grant_o        registered one-hot grant, zero when not valid
//   grant_valid_o  grant_o holds a live grant
//   grant_idx_o    binary index of grant_o, zero when not valid
//   starve_o       registered, some entry has age >= STARVE_LIMIT
module rr_issue_scheduler #(
  parameter int NUM_REQ      = 16,
  parameter int IDX_WIDTH    = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 fu_ready_i,
  input  logic                 flush_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 grant_valid_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o,
  output logic                 starve_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] age_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] age_d [NUM_REQ];
  logic                 starve_q, starve_d;

  logic                 load_en_s;
  logic [NUM_REQ-1:0]   mreq_s;
  logic                 st_hit_s, rr_hit_s, sel_valid_s;
  logic [IDX_WIDTH-1:0] st_idx_s, rr_idx_s, sel_idx_s, cand_s;

  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_idx_o   = idx_q;
  assign starve_o      = starve_q;

  // Load enable and masked request vector (the entry being accepted is not eligible).
  always_comb begin
    load_en_s = !valid_q || fu_ready_i;
    mreq_s    = req_i;
    if (valid_q && fu_ready_i) begin
      mreq_s[idx_q] = 1'b0;
    end else begin
      mreq_s = req_i;
    end
  end

  // Selection: lowest starving entry first, else first request at/after ptr with wrap.
  always_comb begin
    st_hit_s = 1'b0;
    st_idx_s = '0;
    rr_hit_s = 1'b0;
    rr_idx_s = '0;
    cand_s   = '0;
    // Descending scans so the last hit written is the lowest index / smallest offset.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (mreq_s[i] && (age_q[i] >= LIMIT_C)) begin
        st_hit_s = 1'b1;
        st_idx_s = IDX_WIDTH'(i);
      end else begin
        st_hit_s = st_hit_s;
      end
    end
    // Index arithmetic wraps naturally since NUM_REQ == 2**IDX_WIDTH.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = ptr_q + IDX_WIDTH'(k);
      if (mreq_s[cand_s]) begin
        rr_hit_s = 1'b1;
        rr_idx_s = cand_s;
      end else begin
        rr_hit_s = rr_hit_s;
      end
    end
    sel_valid_s = st_hit_s || rr_hit_s;
    sel_idx_s   = st_hit_s ? st_idx_s : rr_idx_s;
  end

  // Next-state for grant register, pointer and age counters.
  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
    end
    if (flush_i) begin
      grant_d = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        age_d[i] = '0;
      end
    end else if (load_en_s) begin
      if (sel_valid_s) begin
        grant_d = NUM_REQ'(1) << sel_idx_s;
        valid_d = 1'b1;
        idx_d   = sel_idx_s;
        ptr_d   = sel_idx_s + IDX_WIDTH'(1);
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
        idx_d   = '0;
      end
      // Ages follow raw req_i: the accepted entry still counts as waiting if it re-requests.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (sel_valid_s && (sel_idx_s == IDX_WIDTH'(i))) begin
          age_d[i] = '0;
        end else if (!req_i[i]) begin
          age_d[i] = '0;
        end else if (age_q[i] != CNT_MAX) begin
          age_d[i] = age_q[i] + CNT_WIDTH'(1);
        end else begin
          age_d[i] = age_q[i];
        end
      end
    end else begin
      grant_d = grant_q;
    end
  end

  // Starvation flag computed from the next-state ages so it is registered alongside them.
  always_comb begin
    starve_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (age_d[i] >= LIMIT_C) begin
        starve_d = 1'b1;
      end else begin
        starve_d = starve_d;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      ptr_q    <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule
